// File: rtl/aes_dec_sched_pkg.sv
// Shared definitions for the AES decipher job scheduler: FSM encodings,
// key-length constants and the watchdog counter width.
package aes_dec_sched_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } state_e;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam int WDOG_W  = 8;
   localparam int BLOCK_W = 128;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win the
// previous accepted grant is chosen.
module aes_rr_arb2
   import aes_dec_sched_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic       grant_valid_o,
   output logic       grant_id_o
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant_id_o = 1'b0;
      if (req_i == 2'b11) begin
         grant_id_o = ~last_grant_q;
      end else if (req_i[1]) begin
         grant_id_o = 1'b1;
      end
   end

   assign grant_valid_o = |req_i;
   assign last_grant_d  = accept_i ? grant_id_o : last_grant_q;

   // Resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/aes_dec_sched.sv
// Schedules decipher jobs from two requesters onto one AES decipher core,
// returns results on a valid/ready stream and guards each job with a watchdog.
module aes_dec_sched
   import aes_dec_sched_pkg::*;
#(
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = 8'd200
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in0_valid,
   output logic               in0_ready,
   input  logic [BLOCK_W-1:0] in0_block,
   input  logic               in0_keylen,
   input  logic               in1_valid,
   output logic               in1_ready,
   input  logic [BLOCK_W-1:0] in1_block,
   input  logic               in1_keylen,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_block,
   output logic               out_id,
   output logic               dec_next,
   output logic               dec_keylen,
   output logic [BLOCK_W-1:0] dec_block,
   input  logic [3:0]         dec_round,
   input  logic [BLOCK_W-1:0] dec_new_block,
   input  logic               dec_ready,
   output logic [4:0]         rk_addr,
   input  logic [BLOCK_W-1:0] rk_data,
   output logic [BLOCK_W-1:0] dec_round_key,
   output logic               err_timeout
);

   state_e               state_q, state_d;
   logic [BLOCK_W-1:0]   op_block_q, op_block_d;
   logic                 op_keylen_q, op_keylen_d;
   logic                 op_id_q, op_id_d;
   logic [BLOCK_W-1:0]   res_q, res_d;
   logic [WDOG_W-1:0]    wdog_q, wdog_d;
   logic                 err_q, err_d;
   logic                 arb_valid;
   logic                 arb_id;
   logic                 accept;

   aes_rr_arb2 u_arb (
      .clk          (clk),
      .reset        (reset),
      .req_i        ({in1_valid, in0_valid}),
      .accept_i     (accept),
      .grant_valid_o(arb_valid),
      .grant_id_o   (arb_id)
   );

   // Next-state logic; the watchdog only runs while waiting on the core,
   // and a completion seen in the same cycle as expiry still wins.
   always_comb begin
      state_d     = state_q;
      op_block_d  = op_block_q;
      op_keylen_d = op_keylen_q;
      op_id_d     = op_id_q;
      res_d       = res_q;
      wdog_d      = wdog_q;
      err_d       = err_q;
      accept      = 1'b0;
      dec_next    = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_valid && !reset) begin
               accept      = 1'b1;
               op_id_d     = arb_id;
               op_block_d  = arb_id ? in1_block : in0_block;
               op_keylen_d = arb_id ? in1_keylen : in0_keylen;
               state_d     = START;
            end
         end
         START: begin
            dec_next = 1'b1;
            wdog_d   = '0;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            wdog_d = wdog_q + 8'd1;
            if (wdog_d == WDOG_LIMIT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (!dec_ready) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            wdog_d = wdog_q + 8'd1;
            if (dec_ready) begin
               res_d   = dec_new_block;
               state_d = RESP;
            end else if (wdog_d == WDOG_LIMIT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         op_block_q  <= '0;
         op_keylen_q <= AES_128_BIT_KEY;
         op_id_q     <= 1'b0;
         res_q       <= '0;
         wdog_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_block_q  <= op_block_d;
         op_keylen_q <= op_keylen_d;
         op_id_q     <= op_id_d;
         res_q       <= res_d;
         wdog_q      <= wdog_d;
         err_q       <= err_d;
      end
   end

   assign in0_ready     = accept & ~arb_id;
   assign in1_ready     = accept & arb_id;
   assign out_block     = res_q;
   assign out_id        = op_id_q;
   assign dec_block     = op_block_q;
   assign dec_keylen    = op_keylen_q;
   assign rk_addr       = {op_id_q, dec_round};
   assign dec_round_key = rk_data;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_aes_dec_sched.sv
// Self-checking bench for aes_dec_sched: behavioural decipher core, round-key
// store and an in-order scoreboard of expected results.
module tb_aes_dec_sched;
   import aes_dec_sched_pkg::*;

   localparam logic [7:0]   LIMIT = 8'd200;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

   typedef struct packed {
      logic         id;
      logic [127:0] blk;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in0_valid, in1_valid, in0_ready, in1_ready;
   logic [127:0] in0_block, in1_block;
   logic         in0_keylen, in1_keylen;
   logic         out_valid, out_ready, out_id;
   logic [127:0] out_block;
   logic         dec_next, dec_keylen, dec_ready;
   logic [127:0] dec_block, dec_new_block;
   logic [3:0]   dec_round;
   logic [4:0]   rk_addr;
   logic [127:0] rk_data, dec_round_key;
   logic         err_timeout;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           coreMode = 0;
   logic         busy;
   logic [127:0] capBlock;
   logic         capLen;

   exp_t         sbQ[$];
   logic         outIds[$];
   logic [4:0]   rkLog[$];
   int           outCount = 0;
   int           ready0Cnt = 0;
   int           ready1Cnt = 0;
   int           nextCyc = 0;
   logic         curId = 1'b0;
   logic [127:0] curBlock = '0;
   logic         curLen = 1'b0;
   logic [127:0] lastOutBlock = '0;
   logic         lastOutId = 1'b0;

   aes_dec_sched #(.WDOG_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .in0_valid    (in0_valid),
      .in0_ready    (in0_ready),
      .in0_block    (in0_block),
      .in0_keylen   (in0_keylen),
      .in1_valid    (in1_valid),
      .in1_ready    (in1_ready),
      .in1_block    (in1_block),
      .in1_keylen   (in1_keylen),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_block    (out_block),
      .out_id       (out_id),
      .dec_next     (dec_next),
      .dec_keylen   (dec_keylen),
      .dec_block    (dec_block),
      .dec_round    (dec_round),
      .dec_new_block(dec_new_block),
      .dec_ready    (dec_ready),
      .rk_addr      (rk_addr),
      .rk_data      (rk_data),
      .dec_round_key(dec_round_key),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Round-key store contents are just a pattern derived from the address.
   assign rk_data = {4{27'd0, rk_addr}};

   // Known FIPS-197 vectors decrypt to the published plaintext; anything
   // else gets a cheap reversible stand-in transform.
   function automatic logic [127:0] coreDecrypt(input logic [127:0] ct, input logic kl);
      if (!kl && ct == CT128) return PT;
      if (kl && ct == CT256) return PT;
      return ct ^ {16{8'h5a}} ^ {128{kl}};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, wanted %h", tag, actual, expected);
      end
   endtask

   // Behavioural decipher core: walks rounds Nr..0 then presents the result;
   // in mode 1 it drops dec_ready and never finishes.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_ready     <= 1'b1;
         busy          <= 1'b0;
         dec_round     <= 4'd0;
         dec_new_block <= '0;
         capBlock      <= '0;
         capLen        <= 1'b0;
      end else if (dec_next) begin
         dec_ready <= 1'b0;
         busy      <= (coreMode == 0);
         dec_round <= dec_keylen ? 4'd14 : 4'd10;
         capBlock  <= dec_block;
         capLen    <= dec_keylen;
      end else if (busy) begin
         if (dec_round == 4'd0) begin
            busy          <= 1'b0;
            dec_ready     <= 1'b1;
            dec_new_block <= coreDecrypt(capBlock, capLen);
         end else begin
            dec_round <= dec_round - 4'd1;
         end
      end
   end

   // Scoreboard and continuous interface checks, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (in0_ready | in1_ready) begin
            checkOutput("ready_onehot", in0_ready & in1_ready, 1'b0);
         end
         if (in0_ready) begin
            sbQ.push_back('{id: 1'b0, blk: coreDecrypt(in0_block, in0_keylen)});
            curId = 1'b0; curBlock = in0_block; curLen = in0_keylen;
            ready0Cnt++;
         end
         if (in1_ready) begin
            sbQ.push_back('{id: 1'b1, blk: coreDecrypt(in1_block, in1_keylen)});
            curId = 1'b1; curBlock = in1_block; curLen = in1_keylen;
            ready1Cnt++;
         end
         if (dec_next) begin
            nextCyc = cyc;
            checkOutput("dec_block", dec_block, curBlock);
            checkOutput("dec_keylen", dec_keylen, curLen);
         end
         if (busy) begin
            rkLog.push_back(rk_addr);
            checkOutput("rk_addr", rk_addr, {curId, dec_round});
            checkOutput("dec_round_key", dec_round_key, rk_data);
            checkOutput("dec_block_hold", dec_block, curBlock);
         end
         if (out_valid && out_ready) begin
            checkOutput("sb_pending", sbQ.size() > 0, 1'b1);
            if (sbQ.size() > 0) begin
               exp_t e;
               e = sbQ.pop_front();
               checkOutput("out_block", out_block, e.blk);
               checkOutput("out_id", out_id, e.id);
            end
            outIds.push_back(out_id);
            lastOutBlock = out_block;
            lastOutId    = out_id;
            outCount++;
         end
      end
   end

   task automatic applyStimulus(input int port, input logic [127:0] blk, input logic kl);
      bit seen;
      seen = 1'b0;
      if (port == 0) begin
         in0_valid = 1'b1; in0_block = blk; in0_keylen = kl;
      end else begin
         in1_valid = 1'b1; in1_block = blk; in1_keylen = kl;
      end
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = (port == 0) ? in0_ready : in1_ready;
      end
      @(posedge clk); #1;
      if (port == 0) in0_valid = 1'b0;
      else in1_valid = 1'b0;
      checkOutput("accept_seen", seen, 1'b1);
   endtask

   task automatic waitOutputs(input int target, input int budget);
      for (int i = 0; i < budget && outCount < target; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("out_count", outCount, target);
   endtask

   initial begin
      int         base, r0, r1, bad, errCyc;
      bit         seen;
      logic [1:0] rem0, rem1;
      logic       expSeq[4];

      reset = 1'b1;
      in0_valid = 1'b1; in1_valid = 1'b1;
      in0_block = '0; in1_block = '0; in0_keylen = 1'b0; in1_keylen = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in0_ready", in0_ready, 1'b0);
      checkOutput("rst_in1_ready", in1_ready, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_dec_next", dec_next, 1'b0);
      checkOutput("rst_out_block", out_block, 128'd0);
      checkOutput("rst_out_id", out_id, 1'b0);
      checkOutput("rst_dec_block", dec_block, 128'd0);
      checkOutput("rst_dec_keylen", dec_keylen, 1'b0);
      checkOutput("rst_err", err_timeout, 1'b0);
      in0_valid = 1'b0; in1_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Contention: both requesters keep two jobs each pending.
      $display("[TB] contention");
      outIds.delete();
      base = outCount; r0 = ready0Cnt; r1 = ready1Cnt;
      rem0 = 2'd2; rem1 = 2'd2;
      in0_valid = 1'b1; in0_block = {4{$urandom()}}; in0_keylen = 1'b0;
      in1_valid = 1'b1; in1_block = {4{$urandom()}}; in1_keylen = 1'b1;
      for (int i = 0; i < 400 && (rem0 != 0 || rem1 != 0); i++) begin
         logic a0, a1;
         @(negedge clk);
         a0 = in0_ready; a1 = in1_ready;
         @(posedge clk); #1;
         if (a0 && rem0 != 0) begin
            rem0 = rem0 - 2'd1; in0_block = {4{$urandom()}};
            if (rem0 == 0) in0_valid = 1'b0;
         end
         if (a1 && rem1 != 0) begin
            rem1 = rem1 - 2'd1; in1_block = {4{$urandom()}};
            if (rem1 == 0) in1_valid = 1'b0;
         end
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      waitOutputs(base + 4, 400);
      expSeq = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr_seq%0d", i), (outIds.size() > i) ? outIds[i] : 1'bx, expSeq[i]);
      end
      checkOutput("ready0_pulses", ready0Cnt - r0, 2);
      checkOutput("ready1_pulses", ready1Cnt - r1, 2);

      // Single AES-128 job.
      $display("[TB] single aes128");
      base = outCount;
      applyStimulus(0, CT128, AES_128_BIT_KEY);
      waitOutputs(base + 1, 100);
      checkOutput("aes128_plain", lastOutBlock, PT);
      checkOutput("aes128_id", lastOutId, 1'b0);

      // Backpressure with a competing job waiting on requester 1.
      $display("[TB] backpressure");
      out_ready = 1'b0;
      base = outCount;
      applyStimulus(0, CT128, AES_128_BIT_KEY);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         seen = out_valid;
      end
      checkOutput("bp_valid_seen", seen, 1'b1);
      in1_valid = 1'b1; in1_block = {4{$urandom()}}; in1_keylen = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_block !== PT || out_valid !== 1'b1 || out_id !== 1'b0 ||
             in0_ready !== 1'b0 || in1_ready !== 1'b0 || dec_next !== 1'b0) bad++;
      end
      checkOutput("bp_bad_cycles", bad, 0);
      checkOutput("bp_no_transfer", outCount, base);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_one_transfer", outCount, base + 1);
      checkOutput("bp_valid_drop", out_valid, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = in1_ready;
      end
      @(posedge clk); #1;
      in1_valid = 1'b0;
      checkOutput("bp_next_accept", seen, 1'b1);
      waitOutputs(base + 2, 100);

      // AES-256 job on requester 1, recording the round-key address walk.
      $display("[TB] aes256");
      base = outCount;
      rkLog.delete();
      applyStimulus(1, CT256, AES_256_BIT_KEY);
      waitOutputs(base + 1, 100);
      checkOutput("aes256_plain", lastOutBlock, PT);
      checkOutput("aes256_id", lastOutId, 1'b1);
      checkOutput("rk_walk_len", rkLog.size(), 15);
      checkOutput("rk_walk_first", (rkLog.size() > 0) ? rkLog[0] : 5'h00, 5'h1e);
      checkOutput("rk_walk_last", (rkLog.size() > 0) ? rkLog[rkLog.size()-1] : 5'h1f, 5'h10);

      // Watchdog: the core never finishes.
      $display("[TB] watchdog");
      coreMode = 1;
      base = outCount;
      checkOutput("wdog_err_pre", err_timeout, 1'b0);
      applyStimulus(0, {4{$urandom()}}, AES_128_BIT_KEY);
      seen = 1'b0;
      errCyc = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = err_timeout;
         errCyc = cyc;
      end
      checkOutput("wdog_fired", seen, 1'b1);
      checkOutput("wdog_cycles", errCyc - (nextCyc + 1), LIMIT);
      checkOutput("wdog_no_out", outCount, base);
      checkOutput("wdog_discard_q", sbQ.size(), 1);
      sbQ.delete();
      @(posedge clk); #1;
      in1_valid = 1'b1; in1_block = {4{$urandom()}}; in1_keylen = 1'b0;
      @(negedge clk);
      checkOutput("wdog_idle_accept", in1_ready, 1'b1);
      @(posedge clk); #1;
      in1_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("wdog_sticky", err_timeout, 1'b1);

      // Reset while the stuck job sits in WAIT_DONE.
      $display("[TB] reset mid-job");
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_out_valid", out_valid, 1'b0);
      checkOutput("mid_rst_err", err_timeout, 1'b0);
      checkOutput("mid_rst_dec_block", dec_block, 128'd0);
      checkOutput("mid_rst_dec_next", dec_next, 1'b0);
      sbQ.delete();
      coreMode = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      base = outCount;
      @(posedge clk); #1;
      checkOutput("post_rst_no_out", outCount, base);
      applyStimulus(0, CT128, AES_128_BIT_KEY);
      waitOutputs(base + 1, 100);
      checkOutput("post_rst_plain", lastOutBlock, PT);
      checkOutput("post_rst_id", lastOutId, 1'b0);
      checkOutput("post_rst_err", err_timeout, 1'b0);
      checkOutput("sb_drained", sbQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
